// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
// Holds the requester count, index width, FSM state encoding and the
// encoder83 lowest-index priority encoding function.
package rr_arbiter8_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    typedef enum logic {
        StIdle  = ST_IDLE,
        StGrant = ST_GRANT
    } state_e;

    // Index of the lowest set bit; 0 when no bit is set (callers check validity).
    function automatic logic [IDX_W-1:0] encoder83(input logic [N_REQ-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        // Scan from the top so the lowest set bit is the last one written.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
//   iReq     : request vector, bit i = requester i
//   oGnt     : one-hot grant, zero when idle
//   oGntIdx  : binary index of the grantee, holds last value when idle
//   oValid   : high while a grant is active
//   oTimeout : one-cycle pulse when a grant is revoked by hold expiry
// master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
    import rr_arbiter8_pkg::*;

    logic [N_REQ-1:0] iReq;
    logic [N_REQ-1:0] oGnt;
    logic [IDX_W-1:0] oGntIdx;
    logic             oValid;
    logic             oTimeout;

    modport master (
        output iReq,
        input  oGnt,
        input  oGntIdx,
        input  oValid,
        input  oTimeout
    );

    modport slave (
        input  iReq,
        output oGnt,
        output oGntIdx,
        output oValid,
        output oTimeout
    );

endinterface

// File: rtl/rr_arbiter8_prio_enc83.sv
// Combinational 8-to-3 lowest-index priority encoder with an any-valid flag.
//   in_i    : input vector
//   idx_o   : index of the lowest set bit (0 when none set)
//   valid_o : high when any bit of in_i is set
module prio_enc83
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] in_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o   = encoder83(in_i);
        valid_o = |in_i;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter sharing one resource between 8 requesters, with a
// per-grant hold limit so no requester can monopolise the resource.
//   iClk : system clock, rising edge
//   iRst : asynchronous active-high reset
//   bus  : request/grant bundle (slave side), see rr_arbiter8_if
// All outputs are registered; grant appears one cycle after the request is sampled.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic         iClk,
    input  logic         iRst,
    rr_arbiter8_if.slave bus
);

    localparam logic [CNT_W-1:0] MaxHold = CNT_W'(MAX_HOLD);

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_REQ-1:0] gnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic             tmo_q;

    logic [IDX_W-1:0]   arb_ptr;
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_valid;
    logic [IDX_W-1:0]   winner;
    logic [N_REQ-1:0]   winner_oh;
    logic               hold_ok;

    // In GRANT any re-arbitration happens on release/timeout, where the
    // pointer moves past the grantee in the same edge; in IDLE use ptr as is.
    always_comb begin
        arb_ptr   = (state_q == StGrant) ? idx_q + IDX_W'(1) : ptr_q;
        req_dbl   = {bus.iReq, bus.iReq} >> arb_ptr;
        req_rot   = req_dbl[N_REQ-1:0];
        winner    = enc_idx + arb_ptr;
        winner_oh = N_REQ'(1) << winner;
        hold_ok   = bus.iReq[idx_q] && (cnt_q < MaxHold);
    end

    prio_enc83 u_enc (
        .in_i    (req_rot),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enc_valid) begin
                        state_q <= StGrant;
                        gnt_q   <= winner_oh;
                        idx_q   <= winner;
                        valid_q <= 1'b1;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                StGrant: begin
                    if (hold_ok) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        // Release or timeout: grantee still requesting means expiry.
                        ptr_q <= arb_ptr;
                        tmo_q <= bus.iReq[idx_q];
                        if (enc_valid) begin
                            gnt_q <= winner_oh;
                            idx_q <= winner;
                            cnt_q <= CNT_W'(1);
                        end else begin
                            state_q <= StIdle;
                            gnt_q   <= '0;
                            valid_q <= 1'b0;
                            cnt_q   <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.oGnt     = gnt_q;
    assign bus.oGntIdx  = idx_q;
    assign bus.oValid   = valid_q;
    assign bus.oTimeout = tmo_q;

endmodule
